// File: rtl/right_shifter_seq_n_bit_pkg.sv
// Shared ALU definitions: FSM state encodings and {N,Z,V,C} flag bit positions.
// Used by right_shifter_seq_n_bit and flag_gen_n_bit.
package right_shifter_seq_n_bit_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_V = 1;
  localparam int FLAG_C = 0;

endpackage

// File: rtl/right_shifter_seq_n_bit_flag_gen.sv
// flag_gen_n_bit: combinational {N,Z,V,C} flag builder shared by the ALU units.
module flag_gen_n_bit
  import right_shifter_seq_n_bit_pkg::*;
#(
  parameter int N = 8
) (
  input  logic [N-1:0] result,
  input  logic         carry,
  input  logic         overflow,
  output logic [3:0]   flags
);

  // Assemble the flag vector from the result and the unit-specific carry/overflow.
  always_comb begin
    flags         = 4'b0000;
    flags[FLAG_N] = result[N-1];
    flags[FLAG_Z] = (result == {N{1'b0}});
    flags[FLAG_V] = overflow;
    flags[FLAG_C] = carry;
  end

endmodule

// File: rtl/right_shifter_seq_n_bit.sv
// Iterative right shifter (logical/arithmetic), one bit per clock, start/busy/done handshake.
// Optional rotate-right mode when RSHIFT_ROTATE_EN is defined.
module right_shifter_seq_n_bit
  import right_shifter_seq_n_bit_pkg::*;
#(
  parameter int N  = 8,
  parameter int SW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [N-1:0]  in_a,
  input  logic [SW-1:0] shift,
  input  logic          arith,
`ifdef RSHIFT_ROTATE_EN
  input  logic          rotate,
`endif
  output logic          busy,
  output logic          done,
  output logic [N-1:0]  out,
  output logic [3:0]    flags_n_z_v_c
);

  state_t        state_r, state_s;
  logic [SW-1:0] count_r;
  logic [N-1:0]  work_r;
  logic          carry_r;
  logic          arith_r;
  logic          rotate_r;
  logic [N-1:0]  out_r;
  logic [3:0]    flags_r;
  logic          busy_r;
  logic          done_r;

  logic          accept_s;
  logic          last_s;
  logic [SW-1:0] load_k_s;
  logic          fill_s;
  logic [N-1:0]  shifted_s;
  logic [N-1:0]  res_s;
  logic          res_carry_s;
  logic [3:0]    flags_s;
  logic          rotate_in_s;

`ifdef RSHIFT_ROTATE_EN
  assign rotate_in_s = rotate;
`else
  assign rotate_in_s = 1'b0;
`endif

  // Accept decode, shift-amount load value and one-step shift datapath.
  always_comb begin
    accept_s = start && ((state_r == ST_IDLE) || (state_r == ST_DONE));
    last_s   = (state_r == ST_SHIFT) && (count_r <= SW'(1));
    if (rotate_in_s) begin
      load_k_s = shift % SW'(N);
    end else if (shift > SW'(N)) begin
      load_k_s = SW'(N);
    end else begin
      load_k_s = shift;
    end
    if (rotate_r) begin
      fill_s = work_r[0];
    end else if (arith_r) begin
      fill_s = work_r[N-1];
    end else begin
      fill_s = 1'b0;
    end
    shifted_s = {fill_s, work_r[N-1:1]};
    // A zero count reaches DONE with the operand untouched and C still cleared.
    if (count_r != {SW{1'b0}}) begin
      res_s       = shifted_s;
      res_carry_s = work_r[0];
    end else begin
      res_s       = work_r;
      res_carry_s = carry_r;
    end
  end

  flag_gen_n_bit #(.N(N)) u_flag_gen (
    .result   (res_s),
    .carry    (res_carry_s),
    .overflow (1'b0),
    .flags    (flags_s)
  );

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE:  state_s = accept_s ? ST_SHIFT : ST_IDLE;
      ST_SHIFT: state_s = last_s ? ST_DONE : ST_SHIFT;
      ST_DONE:  state_s = accept_s ? ST_SHIFT : ST_IDLE;
      default:  state_s = ST_IDLE;
    endcase
  end

  // Operand capture, shifting, counter and result/flag registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_r  <= {SW{1'b0}};
      work_r   <= {N{1'b0}};
      carry_r  <= 1'b0;
      arith_r  <= 1'b0;
      rotate_r <= 1'b0;
      out_r    <= {N{1'b0}};
      flags_r  <= 4'b0000;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      busy_r <= (state_s == ST_SHIFT);
      done_r <= (state_s == ST_DONE);
      if (accept_s) begin
        work_r   <= in_a;
        count_r  <= load_k_s;
        carry_r  <= 1'b0;
        arith_r  <= arith;
        rotate_r <= rotate_in_s;
      end else if ((state_r == ST_SHIFT) && (count_r != {SW{1'b0}})) begin
        work_r  <= shifted_s;
        carry_r <= work_r[0];
        count_r <= count_r - SW'(1);
      end else begin
        count_r <= count_r;
      end
      if (last_s) begin
        out_r   <= res_s;
        flags_r <= flags_s;
      end else begin
        out_r <= out_r;
      end
    end
  end

  assign busy          = busy_r;
  assign done          = done_r;
  assign out           = out_r;
  assign flags_n_z_v_c = flags_r;

endmodule

// File: tb/tb_right_shifter_seq_n_bit.sv
// Scoreboard bench for right_shifter_seq_n_bit: driver pushes expectations, negedge monitor checks on done.
module tb_right_shifter_seq_n_bit;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] in_a;
  logic [3:0] shift;
  logic       arith;
  logic       rotate;
  logic       busy;
  logic       done;
  logic [7:0] out;
  logic [3:0] flags_n_z_v_c;

  typedef struct {
    logic [7:0] eo;
    logic [3:0] ef;
    int         lat;
    int         acc_cyc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   busy_cnt = 0;

  right_shifter_seq_n_bit #(.N(8), .SW(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .in_a          (in_a),
    .shift         (shift),
    .arith         (arith),
`ifdef RSHIFT_ROTATE_EN
    .rotate        (rotate),
`endif
    .busy          (busy),
    .done          (done),
    .out           (out),
    .flags_n_z_v_c (flags_n_z_v_c)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: compare every done pulse against the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      busy_cnt = 0;
    end else begin
      if (busy) busy_cnt++;
      if (done) begin
        if (sb.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          e = sb.pop_front();
          chk("out", int'(out), int'(e.eo));
          chk("flags", int'(flags_n_z_v_c), int'(e.ef));
          chk("latency", cyc - e.acc_cyc, e.lat);
          if (e.lat > 1 || busy_cnt == 1) chk("busy_cycles", busy_cnt, e.lat);
        end
        busy_cnt = 0;
      end
    end
  end

  task automatic issue(input logic [7:0] a, input logic [3:0] sh, input logic ar,
                       input logic [7:0] eo, input logic [3:0] ef, input int el, input bit push);
    exp_t e;
    in_a = a; shift = sh; arith = ar; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    e.eo = eo; e.ef = ef; e.lat = el; e.acc_cyc = cyc;
    if (push) sb.push_back(e);
  endtask

  task automatic wait_done();
    bit seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) chk("done_timeout", 0, 1);
  endtask

  task automatic do_op(input logic [7:0] a, input logic [3:0] sh, input logic ar,
                       input logic [7:0] eo, input logic [3:0] ef, input int el);
    issue(a, sh, ar, eo, ef, el, 1'b1);
    wait_done();
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; in_a = 8'h00; shift = 4'd0; arith = 1'b0; rotate = 1'b0;
    #3;
    chk("rst_out", int'(out), 0);
    chk("rst_flags", int'(flags_n_z_v_c), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    do_op(8'hF0, 4'd1,  1'b0, 8'h78, 4'b0000, 1);
    do_op(8'hF0, 4'd3,  1'b1, 8'hFE, 4'b1000, 3);
    do_op(8'hF0, 4'd6,  1'b0, 8'h03, 4'b0001, 6);
    do_op(8'h81, 4'd9,  1'b0, 8'h00, 4'b0101, 8);
    do_op(8'h81, 4'd9,  1'b1, 8'hFF, 4'b1001, 8);
    do_op(8'h00, 4'd0,  1'b0, 8'h00, 4'b0100, 1);
    do_op(8'h70, 4'd4,  1'b1, 8'h07, 4'b0000, 4);
    do_op(8'h7F, 4'd15, 1'b1, 8'h00, 4'b0100, 8);
    do_op(8'h81, 4'd8,  1'b0, 8'h00, 4'b0101, 8);

    // Start pulse mid-SHIFT must be ignored; then back-to-back accept from DONE.
    issue(8'hF0, 4'd5, 1'b0, 8'h07, 4'b0001, 5, 1'b1);
    @(negedge clk);
    @(negedge clk);
    in_a = 8'h0F; shift = 4'd1; arith = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done();
    issue(8'h81, 4'd2, 1'b1, 8'hE0, 4'b1000, 2, 1'b1);
    @(negedge clk);
    chk("b2b_busy", int'(busy), 1);
    wait_done();
    @(negedge clk);

    // Asynchronous reset during SHIFT aborts without a done pulse.
    issue(8'hF0, 4'd5, 1'b0, 8'h00, 4'b0000, 5, 1'b0);
    @(negedge clk);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("abort_out", int'(out), 0);
    chk("abort_flags", int'(flags_n_z_v_c), 0);
    chk("abort_busy", int'(busy), 0);
    chk("abort_done", int'(done), 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    chk("sb_empty", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule

// File: doc/right_shifter_seq_n_bit.md
Name: right_shifter_seq_n_bit

Overview:
- Iterative N-bit right shifter for the ALU; the reverse-direction counterpart of the combinational left shifter.
- Performs logical or arithmetic right shift, one bit position per clock, under a start/busy/done handshake.
- Produces the ALU's standard 4-bit flag vector {N,Z,V,C} with the result.
- Area-cheap alternative to a barrel shifter for the multi-cycle ALU path.

Parameters:
- N, 8, data width in bits.
- SW, 4, shift-amount width; must satisfy 2^SW > N.

Ports:
- clk  input  1  clock; all state changes on rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only when accepting (IDLE or DONE state).
- in_a  input  N  operand; captured at accept edge.
- shift  input  SW  shift amount; captured at accept edge.
- arith  input  1  1 = arithmetic (sign-fill), 0 = logical (zero-fill); captured at accept.
- busy  output  1  high while in SHIFT state.
- done  output  1  one-cycle pulse; result and flags valid.
- out  output  N  result; holds until next accept or reset.
- flags_n_z_v_c  output  4  {N,Z,V,C}; holds with out.

Behaviour:
- Reset (async, any state): state=IDLE; out=0, flags=0000, busy=0, done=0, internal count=0.
- States:
  - IDLE: waiting.
  - SHIFT: shifting; busy=1.
  - DONE: result valid; done=1 for exactly one cycle.
- Accept: in IDLE or DONE with start=1, capture operands on the edge. Load working register=in_a and k=min(shift,N) (saturate). Clear the C accumulator.
- k>=1: go to SHIFT. Each SHIFT edge shifts right by one, filling MSB with (arith ? reg[N-1] : 0), sets C=bit shifted out, and decrements count. The edge where count goes 1->0 moves to DONE.
- k==0: go straight to DONE on the next edge with out=in_a and C=0.
- Latency: done is high in the cycle after edge max(k,1) counted from the accept edge. Latency is max(k,1) cycles, and at most N.
- DONE: with start=0 go to IDLE next edge. With start=1 accept a new op (back-to-back, no idle bubble).
- start while in SHIFT is ignored. Operands are not re-sampled mid-operation.
- out and flags update only on entry to DONE; they hold otherwise.
- Flags:
  - N = out[N-1].
  - Z = (out==0).
  - V = 0 always (right shift cannot overflow).
  - C = last bit shifted out.
- Saturation results, shift >= N:
  - logical: out=0.
  - arithmetic: out=all copies of in_a[N-1].
- Reset mid-SHIFT: abort immediately; no done pulse; outputs cleared.

Optional Feature:
- Macro: RSHIFT_ROTATE_EN.
- Enabled:
  - Extra input port rotate (1 bit), captured at accept.
  - rotate=1 performs rotate-right: MSB fill = bit shifted out; arith ignored; count is shift mod N, not saturated.
  - C = last bit rotated out.
  - Z and N computed as normal; V=0.
- Disabled: port absent; behaviour exactly as above.

Decomposition:
- Shared ALU header `define`s:
  - state encodings: IDLE=2'd0, SHIFT=2'd1, DONE=2'd2.
  - flag bit indices: N=3, Z=2, V=1, C=0. These are shared with the other ALU units.
- Sub-module flag_gen_n_bit (combinational, parameter N): produces {N,Z,V,C} from result, carry and overflow inputs. Reusable across ALU units.
- The FSM, counter and datapath stay in the top module.

Test Plan:
- in_a=11110000, shift=1, arith=0 -> done 1 cycle after accept; out=01111000, flags=0000.
- in_a=11110000, shift=3, arith=1 -> done 3 cycles after accept; out=11111110, flags=1000.
- in_a=11110000, shift=6, arith=0 -> done 6 cycles after accept; out=00000011, flags=0001 (C=old bit5); busy high for exactly 6 cycles.
- in_a=10000001, shift=9 (saturates):
  - arith=0 -> out=00000000, flags=0101.
  - arith=1 -> out=11111111, flags=1001.
  - Both cases: done 8 cycles after accept.
- shift=0, in_a=00000000 -> done 1 cycle later; out=00000000, flags=0100. Start pulse during SHIFT of a prior op is ignored; start held in DONE -> back-to-back accept with no IDLE cycle.
- Assert rst during SHIFT (shift=5, cycle 2) -> out=0, flags=0000, busy=0 immediately (asynchronous); no done pulse afterwards.
